// File: rtl/apb_mem_slave_p.sv
// APB memory slave: DEPTH words of DATA_W bits, byte-lane strobes, programmable wait states,
// registered read data/ready/error outputs, PSLVERR on word index >= DEPTH.
module apb_mem_slave_p #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W/8-1:0]   PSTRB,
  output logic [DATA_W-1:0]     PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned StrbW    = DATA_W / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    strb_q, strb_d;
  logic                err_q, err_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rd_word;
  logic [ADDR_W-1:0]   rd_addr;
  logic [IdxW-1:0]     rd_idx, wr_idx;
  logic                setup, new_err;
  logic                enter_done, enter_write, enter_err;

  always_comb begin
    setup   = PSEL && !PENABLE;
    new_err = {1'b0, PADDR} >= DepthLim;
    // A zero-wait transfer enters DONE on the setup edge, before addr_q/write_q/err_q hold it.
    rd_addr     = (state_q == StIdle) ? PADDR : addr_q;
    enter_write = (state_q == StIdle) ? PWRITE : write_q;
    enter_err   = (state_q == StIdle) ? new_err : err_q;
    rd_idx      = rd_addr[IdxW-1:0];
    rd_word     = mem_q[rd_idx];
    wr_idx      = addr_q[IdxW-1:0];
    mem_wdata   = mem_q[wr_idx];
    for (int i = 0; i < int'(StrbW); i++) begin
      if (strb_q[i]) mem_wdata[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    err_d      = err_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;
    prdata_d   = prdata_q;
    mem_we     = 1'b0;
    enter_done = 1'b0;

    case (state_q)
      StIdle: begin
        if (setup) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          err_d   = new_err;
          if (WAIT_STATES == 0) begin
            enter_done = 1'b1;
          end else begin
            cnt_d   = WaitInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!PSEL) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (!PSEL || PENABLE) begin
          mem_we    = PSEL && write_q && !err_q;
          state_d   = StIdle;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_done) begin
      state_d   = StDone;
      cnt_d     = '0;
      pready_d  = 1'b1;
      pslverr_d = enter_err;
      prdata_d  = (enter_write || enter_err) ? '0 : rd_word;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Storage is deliberately not reset; mem_we is already gated by the reset-cleared FSM.
  always_ff @(posedge PCLK) begin
    if (mem_we) mem_q[wr_idx] <= mem_wdata;
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule
